// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports and single-port memory bus
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic              i_valid;
   logic [DATA_W-1:0] i_data;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ack, i_valid, i_data, d_ack, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_valid, i_data, d_ack, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - instruction/data arbiter for one single-port synchronous memory
// Data wins contention until it has taken MAX_DATA_BURST grants in a row while fetch waits.
module mem_port_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int MAX_DATA_BURST = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus
);
   localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   logic              grant_i;
   logic              grant_d;
   logic [3:0]        streak;
   logic [3:0]        streak_nxt;
   owner_t            owner;
   owner_t            owner_nxt;

   logic              i_ack_q;
   logic              d_ack_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   always_comb begin
      grant_d = bus.d_req && (!bus.i_req || (streak != MAX_CNT));
      grant_i = bus.i_req && !grant_d;
   end

   always_comb begin
      streak_nxt = streak;
      if (!bus.i_req || grant_i) begin
         streak_nxt = 4'd0;
      end else if (grant_d && (streak != MAX_CNT)) begin
         streak_nxt = streak + 4'd1;
      end
   end

   // The ack cycle of a read becomes the response cycle owner on the next edge.
   always_comb begin
      owner_nxt = OWN_NONE;
      if (i_ack_q) begin
         owner_nxt = OWN_I;
      end else if (d_ack_q && !mem_we_q) begin
         owner_nxt = OWN_D;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak      <= 4'd0;
         owner       <= OWN_NONE;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         streak   <= streak_nxt;
         owner    <= owner_nxt;
         i_ack_q  <= grant_i;
         d_ack_q  <= grant_d;
         mem_en_q <= grant_i || grant_d;
         mem_we_q <= grant_d && bus.d_we;
         if (grant_d) begin
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
         end else if (grant_i) begin
            mem_addr_q  <= bus.i_addr;
         end
      end
   end

   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Read data is gated by the owner so idle and reset cycles present zeros.
   assign bus.i_valid = (owner == OWN_I);
   assign bus.d_valid = (owner == OWN_D);
   assign bus.i_data  = (owner == OWN_I) ? bus.mem_rdata : '0;
   assign bus.d_rdata = (owner == OWN_D) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a synchronous memory model
module tb_mem_port_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   logic [15:0] mem [0:65535];

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_port_arbiter #(
      .ADDR_W(16),
      .DATA_W(16),
      .MAX_DATA_BURST(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {27'd0, bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.i_valid, bus.d_valid}, 32'd0);
      check({tag, "_bus"}, {bus.mem_addr, bus.mem_wdata}, 32'd0);
      check({tag, "_rd"},  {bus.i_data, bus.d_rdata}, 32'd0);
   endtask

   initial begin
      string order;
      logic [15:0] fetch_word [0:3];
      n_checks = 0;
      n_pass   = 0;
      order    = "DDIDDI";
      fetch_word[0] = 16'hFF10;
      fetch_word[1] = 16'h1111;
      fetch_word[2] = 16'h2222;
      fetch_word[3] = 16'h3333;
      for (int k = 0; k < 4; k++) mem[k] = fetch_word[k];
      bus.mem_rdata = 16'h0;
      bus.i_req = 1'b0; bus.i_addr = 16'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
      rst_n = 1'b0;

      step(); step();
      check_all_zero("reset");
      rst_n = 1'b1;

      // Instruction read of 0x0000
      bus.i_req = 1'b1; bus.i_addr = 16'h0000;
      step();
      check("ifetch_ack", {bus.i_ack, bus.d_ack, bus.mem_en, bus.mem_we}, 32'b1010);
      check("ifetch_addr", bus.mem_addr, 32'h0000);
      bus.i_req = 1'b0;
      step();
      check("ifetch_valid", {bus.i_valid, bus.d_valid, bus.i_ack, bus.d_ack}, 32'b1000);
      check("ifetch_data", bus.i_data, 32'hFF10);
      step();
      check("ifetch_valid_off", bus.i_valid, 32'd0);

      // Write 0xAAAA to 0xFFFF, then read it back
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'hFFFF; bus.d_wdata = 16'hAAAA;
      step();
      check("wr_ack", {bus.d_ack, bus.i_ack, bus.mem_en, bus.mem_we}, 32'b1011);
      check("wr_bus", {bus.mem_addr, bus.mem_wdata}, 32'hFFFF_AAAA);
      bus.d_we = 1'b0;
      step();
      check("rd_ack", {bus.d_ack, bus.mem_en, bus.mem_we, bus.d_valid}, 32'b1100);
      check("rd_addr", bus.mem_addr, 32'hFFFF);
      bus.d_req = 1'b0;
      step();
      check("rd_valid", {bus.d_valid, bus.i_valid, bus.mem_en, bus.mem_we}, 32'b1000);
      check("rd_data", bus.d_rdata, 32'hAAAA);

      // Idle for 10 cycles
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("idle%0d_ctl", k),
               {27'd0, bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.i_valid, bus.d_valid}, 32'd0);
         check($sformatf("idle%0d_addr", k), bus.mem_addr, 32'hFFFF);
      end

      // Contention with MAX_DATA_BURST=2
      bus.i_req = 1'b1; bus.i_addr = 16'h0002;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0001;
      for (int k = 0; k < 6; k++) begin
         step();
         if (order[k] == "D") begin
            check($sformatf("cont%0d_ack", k), {bus.i_ack, bus.d_ack}, 32'b01);
            check($sformatf("cont%0d_addr", k), bus.mem_addr, 32'h0001);
         end else begin
            check($sformatf("cont%0d_ack", k), {bus.i_ack, bus.d_ack}, 32'b10);
            check($sformatf("cont%0d_addr", k), bus.mem_addr, 32'h0002);
         end
         if (k > 0) begin
            check($sformatf("cont%0d_valid", k), {bus.i_valid, bus.d_valid},
                  (order[k-1] == "D") ? 32'b01 : 32'b10);
            check($sformatf("cont%0d_data", k), {bus.i_data, bus.d_rdata},
                  (order[k-1] == "D") ? 32'h0000_1111 : 32'h2222_0000);
         end
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      step();
      check("cont_tail_valid", {bus.i_valid, bus.d_valid, bus.i_ack, bus.d_ack}, 32'b1000);
      step();

      // Back-to-back fetch of 0x0000..0x0003
      bus.i_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.i_addr = 16'(k);
         step();
         check($sformatf("b2b%0d_ack", k), {bus.i_ack, bus.d_ack}, 32'b10);
         check($sformatf("b2b%0d_addr", k), bus.mem_addr, 32'(k));
         if (k > 0) begin
            check($sformatf("b2b%0d_valid", k), bus.i_valid, 32'd1);
            check($sformatf("b2b%0d_data", k), bus.i_data, 32'(fetch_word[k-1]));
         end else begin
            check("b2b0_novalid", bus.i_valid, 32'd0);
         end
      end
      bus.i_req = 1'b0;
      step();
      check("b2b_last_valid", {bus.i_valid, bus.i_ack}, 32'b10);
      check("b2b_last_data", bus.i_data, 32'h3333);
      step();

      // Reset in the cycle after a read's d_ack
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0001;
      step();
      check("rst_rd_ack", bus.d_ack, 32'd1);
      bus.d_req = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      step();
      rst_n = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 16'h0003;
      step();
      check("post_rst_ack", {bus.i_ack, bus.d_ack, bus.d_valid}, 32'b100);
      bus.i_req = 1'b0;
      step();
      check("post_rst_valid", {bus.i_valid, bus.d_valid}, 32'b10);
      check("post_rst_data", bus.i_data, 32'h3333);
      step();
      check("post_rst_quiet", {bus.i_valid, bus.d_valid}, 32'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 The block SHALL have parameter MAX_DATA_BURST, default 2, the maximum number of consecutive data grants while instruction fetch waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_req  input  1  instruction fetch request; held with i_addr stable until i_ack.
REQ-007 i_addr  input  ADDR_W  fetch address.
REQ-008 i_ack  output  1  one-cycle pulse; fetch request accepted.
REQ-009 i_valid  output  1  one-cycle pulse; i_data holds the fetched word.
REQ-010 i_data  output  DATA_W  fetched instruction word.
REQ-011 d_req  input  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_ack  output  1  one-cycle pulse; data request accepted.
REQ-016 d_valid  output  1  one-cycle pulse; d_rdata holds the read word; never asserted for writes.
REQ-017 d_rdata  output  DATA_W  data read word.
REQ-018 mem_en  output  1  single-port synchronous memory enable.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  ADDR_W  memory address.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid one cycle after the mem_en cycle.

Function
REQ-023 The block SHALL sample i_req and d_req at each posedge and issue at most one access per cycle; mem_en, mem_we, mem_addr, mem_wdata and the matching ack SHALL be registered and high during cycle t+1 for a request sampled at edge t.
REQ-024 A req still high during its own ack cycle SHALL be treated as a new request, enabling back-to-back accesses every cycle.
REQ-025 For reads, the block SHALL assert i_valid or d_valid in cycle t+2 and route mem_rdata through to i_data or d_rdata, using a registered owner tag.
REQ-026 Arbitration SHALL follow these rules: only one request → grant it; both → grant data unless the streak counter equals MAX_DATA_BURST, in which case grant instruction.
REQ-027 The streak counter SHALL increment on each data grant made while i_req is high.
REQ-028 The streak counter SHALL clear on any instruction grant and on any cycle where i_req is low; it SHALL saturate at MAX_DATA_BURST.
REQ-029 With no request sampled, mem_en, mem_we, i_ack and d_ack SHALL be 0 in the next cycle; mem_addr and mem_wdata SHALL hold their last values.
REQ-030 A write SHALL drive mem_we=1 with d_addr and d_wdata in its ack cycle and SHALL produce no valid pulse.
REQ-031 i_valid and d_valid SHALL never be asserted in the same cycle; i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-032 An address at the top of the range (all ones) SHALL pass unchanged, with no wrap or offset applied.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0, the streak counter SHALL be 0 and the owner tag SHALL be cleared.
REQ-034 Reset asserted mid-operation SHALL discard any pending read response; no valid SHALL pulse after reset release until a new request is sampled.
REQ-035 The first edge with rst_n=1 SHALL sample requests normally.

Verification
REQ-036 Instruction read: i_req=1, i_addr=0x0000, memory word 0xFF10 → i_ack in cycle 1, i_valid in cycle 2 with i_data=0xFF10, d_ack=0.
REQ-037 Write then read: d_we=1, d_addr=0xFFFF, d_wdata=0xAAAA, followed by a read of 0xFFFF → mem_we=1 only in the write ack cycle; d_valid with d_rdata=0xAAAA two cycles after the read is sampled; no valid for the write.
REQ-038 Contention: i_req and d_req held continuously with MAX_DATA_BURST=2 → grant order D,D,I,D,D,I; exactly one ack per cycle.
REQ-039 Idle: both requests low for 10 cycles → mem_en=0 and all acks and valids 0 throughout; mem_addr holds its last value.
REQ-040 Reset mid-read: rst_n pulled low in the cycle after d_ack of a read → all outputs 0 immediately; no d_valid after release.
REQ-041 Back-to-back fetch: i_req held high for fetches of 0x0000..0x0003 → i_ack on 4 consecutive cycles; i_valid on 4 consecutive cycles, each one cycle after its ack.
